// File: rtl/pow_5_res_fifo_pkg.sv
// Shared defaults for the power-of-5 result buffer.
// Also provides the occupancy-counter width helper.
package pow_5_res_fifo_pkg;

   localparam int W            = 8;
   localparam int DEPTH        = 8;
   localparam int AFULL_MARGIN = 5;

   // The counter must represent 0..depth inclusive, hence depth+1.
   function automatic int cnt_w(input int d);
      return $clog2(d + 1);
   endfunction

endpackage

// File: rtl/pow_5_fifo_mem.sv
// Result storage: one synchronous write port and one asynchronous read port.
// The storage is deliberately left without a reset.
module pow_5_fifo_mem
   import pow_5_res_fifo_pkg::*;
#(
   parameter int w     = W,
   parameter int depth = DEPTH,
   parameter int aw    = (depth > 1) ? $clog2(depth) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [aw-1:0] waddr,
   input  logic [w-1:0]  wdata,
   input  logic [aw-1:0] raddr,
   output logic [w-1:0]  rdata
);

   logic [w-1:0] mem_q [depth];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/pow_5_res_fifo.sv
// Show-ahead result FIFO behind the power-of-5 pipeline. Captures on clk_en,
// drains over valid/ready, and raises almost_full early enough to absorb in-flight results.
module pow_5_res_fifo
   import pow_5_res_fifo_pkg::*;
#(
   parameter int w            = W,
   parameter int depth        = DEPTH,
   parameter int afull_margin = AFULL_MARGIN
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clk_en,
   input  logic                     in_vld,
   input  logic [w-1:0]             in_data,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic [w-1:0]             out_data,
   output logic [cnt_w(depth)-1:0]  count,
   output logic                     full,
   output logic                     almost_full,
   output logic                     overflow,
   input  logic                     ovf_clr
);

   localparam int AW = (depth > 1) ? $clog2(depth) : 1;
   localparam int CW = cnt_w(depth);
   localparam logic [CW-1:0] FULL_CNT  = CW'(depth);
   localparam logic [CW-1:0] AFULL_CNT = CW'(depth - afull_margin);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, afull_q, vld_q;
   logic          ovf_q, ovf_d;
   logic          push_req, push_ok, pop, drop;

   always_comb begin
      push_req = in_vld & clk_en;
      pop      = vld_q & out_rdy;
      // A pop on the same edge frees the slot, so a full FIFO still accepts.
      push_ok  = push_req & (~full_q | pop);
      drop     = push_req & ~push_ok;

      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

      count_d = count_q;
      if (push_ok && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push_ok && pop) begin
         count_d = count_q - CW'(1);
      end

      // Set wins over a coincident clear.
      ovf_d = drop | (ovf_q & ~ovf_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         vld_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= (count_d == FULL_CNT);
         afull_q  <= (count_d >= AFULL_CNT);
         vld_q    <= (count_d != '0);
         ovf_q    <= ovf_d;
      end
   end

   pow_5_fifo_mem #(
      .w     (w),
      .depth (depth),
      .aw    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wr_ptr_q),
      .wdata (in_data),
      .raddr (rd_ptr_q),
      .rdata (out_data)
   );

   assign out_vld     = vld_q;
   assign count       = count_q;
   assign full        = full_q;
   assign almost_full = afull_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_pow_5_res_fifo.sv
// Bench for pow_5_res_fifo: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based reference.
module tb_pow_5_res_fifo;
   import pow_5_res_fifo_pkg::*;

   localparam int CW = cnt_w(DEPTH);

   logic          clk = 1'b0;
   logic          rst;
   logic          clk_en;
   logic          in_vld;
   logic [W-1:0]  in_data;
   logic          out_vld;
   logic          out_rdy;
   logic [W-1:0]  out_data;
   logic [CW-1:0] count;
   logic          full;
   logic          almost_full;
   logic          overflow;
   logic          ovf_clr;

   int checks   = 0;
   int failures = 0;

   // Reference state: contents in order, plus the sticky drop flag.
   logic [W-1:0] mq[$];
   bit           m_ovf = 1'b0;

   pow_5_res_fifo dut (
      .clk         (clk),
      .rst         (rst),
      .clk_en      (clk_en),
      .in_vld      (in_vld),
      .in_data     (in_data),
      .out_vld     (out_vld),
      .out_rdy     (out_rdy),
      .out_data    (out_data),
      .count       (count),
      .full        (full),
      .almost_full (almost_full),
      .overflow    (overflow),
      .ovf_clr     (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference update: pop happens first so a full queue accepts a push alongside a pop.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
         end else begin
            bit do_push, do_pop, was_full, dropped;
            do_push  = in_vld && clk_en;
            do_pop   = (mq.size() > 0) && out_rdy;
            was_full = (mq.size() == DEPTH);
            dropped  = 1'b0;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
               if (!was_full || do_pop) mq.push_back(in_data);
               else dropped = 1'b1;
            end
            m_ovf = dropped ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
         end
      end
   end

   // Per-cycle comparison against the reference, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            int sz;
            sz = mq.size();
            chk("m_out_vld", out_vld, (sz > 0));
            chk("m_count", count, sz);
            chk("m_full", full, (sz == DEPTH));
            chk("m_almost_full", almost_full, (sz >= DEPTH - AFULL_MARGIN));
            chk("m_overflow", overflow, m_ovf);
            if (sz > 0) chk("m_out_data", out_data, mq[0]);
         end
      end
   end

   task automatic drive(input logic vld, input logic [W-1:0] d, input logic en,
                        input logic rdy, input logic clr, input bit verbose);
      in_vld  = vld;
      in_data = d;
      clk_en  = en;
      out_rdy = rdy;
      ovf_clr = clr;
      @(posedge clk);
      #1;
      if (verbose)
         $display("txn vld=%0b data=%0d en=%0b rdy=%0b clr=%0b -> out_vld=%0b out_data=%0d count=%0d af=%0b full=%0b ovf=%0b",
                  vld, d, en, rdy, clr, out_vld, out_data, count, almost_full, full, overflow);
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic drain_all();
      for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b1; clk_en = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0; ovf_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", count, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_full", full, 0);
      chk("rst_almost_full", almost_full, 0);
      chk("rst_overflow", overflow, 0);
      rst = 1'b0;
      idle();

      // 1: single push of 3^5, then pop
      drive(1'b1, 8'd243, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t1_out_vld", out_vld, 1);
      chk("t1_out_data", out_data, 243);
      chk("t1_count", count, 1);
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("t1_pop_out_vld", out_vld, 0);
      chk("t1_pop_count", count, 0);

      // 2: held valid, one clk_en cycle captures exactly once
      drive(1'b1, 8'd32, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'd32, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'd32, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'd32, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t2_count", count, 1);
      chk("t2_out_data", out_data, 32);
      drain_all();

      // 3: fill, thresholds, overflow, ordered drain
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, W'(i), 1'b1, 1'b0, 1'b0, 1'b1);
         if (i == 2) chk("t3_af_below", almost_full, 0);
         if (i == 3) chk("t3_af_at3", almost_full, 1);
         if (i == 7) chk("t3_full_at7", full, 0);
      end
      chk("t3_full", full, 1);
      drive(1'b1, 8'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t3_overflow", overflow, 1);
      chk("t3_count", count, 8);
      for (int i = 1; i <= 8; i++) begin
         chk("t3_drain", out_data, i);
         drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
      end
      chk("t3_empty", out_vld, 0);

      // 5a: clear sticky overflow
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("t5_clr", overflow, 0);

      // 4: full with simultaneous push and pop
      for (int i = 1; i <= 8; i++) drive(1'b1, W'(i), 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'd9, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("t4_count", count, 8);
      chk("t4_overflow", overflow, 0);
      for (int i = 2; i <= 9; i++) begin
         chk("t4_drain", out_data, i);
         drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
      end

      // 5b: clear coincident with a drop leaves overflow set
      for (int i = 1; i <= 8; i++) drive(1'b1, W'(i), 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'd77, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("t5_set_wins", overflow, 1);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
      drain_all();

      // 6: asynchronous reset mid-cycle with 5 entries held
      for (int i = 1; i <= 5; i++) drive(1'b1, W'(10 + i), 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t6_pre_count", count, 5);
      in_vld = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_count", count, 0);
      chk("t6_rst_out_vld", out_vld, 0);
      chk("t6_rst_full", full, 0);
      chk("t6_rst_almost_full", almost_full, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      drive(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t6_out_vld", out_vld, 1);
      chk("t6_out_data", out_data, 0);
      drain_all();

      // Random traffic, checked every cycle by the compare process.
      for (int n = 0; n < 1500; n++) begin
         drive(($urandom_range(0, 3) != 0), W'($urandom()), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), 1'b0);
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
